// File: rtl/unibus_intr_pkg.sv
// unibus_intr_pkg
//   Shared definitions for the Unibus BR/BG interrupt master:
//   transaction state encoding, timing defaults, and the
//   level-to-BR/BG bit mapping.
package unibus_intr_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAITBUS  = 3'd2,
      ST_INTR     = 3'd3,
      ST_WAITSSYN = 3'd4,
      ST_RELEASE  = 3'd5
   } state_t;

   // Timing defaults, in 100MHz clock cycles.
   localparam int DEBNC_DEF   = 4;
   localparam int SETTLE_DEF  = 15;
   localparam int TIMEOUT_DEF = 1000;

   // Width of the shared delay counter; it must hold TIMEOUT.
   localparam int CNT_W = 10;

   // Levels 4..7 map onto BR/BG bits 0..3, so only lev[1:0] selects the bit.
   function automatic logic [3:0] lev_mask(input logic [2:0] lev);
      lev_mask = 4'b0001 << lev[1:0];
   endfunction

endpackage

// File: rtl/unibus_intr.sv
// unibus_intr
//   Unibus interrupt master. Requests the bus at BR4..BR7 for the level
//   on irqlev, takes the matching BG grant out of the daisy chain, puts
//   the vector on D with INTR, waits for SSYN, then releases the bus.
//   One interrupt is issued per distinct non-idle {irqlev, irqvec} value.
// Ports
//   CLOCK, RESET      100MHz clock, synchronous active-high reset
//   init_in_h         Unibus INIT, same effect as RESET
//   irqlev, irqvec    requested level (4..7 active) and vector bits 7:2
//   bg_in_l/bg_out_l  BG7..BG4 daisy chain in/out (active low)
//   br_out_h          BR7..BR4 request
//   bbsy_in_h, syn_msyn_in_h, syn_ssyn_in_h, del_ssyn_in_h  bus status
//   bbsy_out_h, sack_out_h, intr_out_h, d_out_h             bus drive
//   intdone           one-cycle pulse when the vector was accepted
//   inttimo           sticky: the last INTR got no SSYN
module unibus_intr
   import unibus_intr_pkg::*;
#(
   parameter int DEBNC   = DEBNC_DEF,
   parameter int SETTLE  = SETTLE_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
)(
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        init_in_h,
   input  logic [2:0]  irqlev,
   input  logic [5:0]  irqvec,
   input  logic [3:0]  bg_in_l,
   output logic [3:0]  bg_out_l,
   output logic [3:0]  br_out_h,
   input  logic        bbsy_in_h,
   input  logic        syn_msyn_in_h,
   input  logic        syn_ssyn_in_h,
   input  logic        del_ssyn_in_h,
   output logic        bbsy_out_h,
   output logic        sack_out_h,
   output logic        intr_out_h,
   output logic [15:0] d_out_h,
   output logic        intdone,
   output logic        inttimo
);

   localparam logic [CNT_W-1:0] DEBNC_LAST   = CNT_W'(DEBNC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_r;
   logic [2:0]       lev_r;
   logic [5:0]       vec_r;
   logic [2:0]       last_lev_r;
   logic [5:0]       last_vec_r;
   logic [CNT_W-1:0] cnt_r;
   logic             ssyn_seen_r;
   logic [3:0]       br_r;
   logic             bbsy_r;
   logic             sack_r;
   logic             intr_r;
   logic [15:0]      d_r;
   logic             intdone_r;
   logic             inttimo_r;

   logic             req_change_s;
   logic             new_req_s;
   logic             grant_s;
   logic             past_req_s;
   logic [3:0]       bg_out_s;

   assign req_change_s = ({irqlev, irqvec} != {lev_r, vec_r});
   assign new_req_s    = (irqlev[2] == 1'b1) && ({irqlev, irqvec} != {last_lev_r, last_vec_r});
   assign grant_s      = ~bg_in_l[lev_r[1:0]];
   assign past_req_s   = (state_r == ST_WAITBUS) || (state_r == ST_INTR) ||
                         (state_r == ST_WAITSSYN) || (state_r == ST_RELEASE);

   // Grant chain: block our own level once we request or own the bus, pass all others through.
   always_comb begin
      bg_out_s = bg_in_l;
      for (int n = 0; n < 4; n++) begin
         if (br_r[n] || (past_req_s && (lev_r[1:0] == 2'(n)))) begin
            bg_out_s[n] = 1'b1;
         end else begin
            bg_out_s[n] = bg_in_l[n];
         end
      end
   end

   // Interrupt transaction sequencer with registered bus drive.
   always_ff @(posedge CLOCK) begin
      if (RESET || init_in_h) begin
         state_r     <= ST_IDLE;
         lev_r       <= 3'd0;
         vec_r       <= 6'd0;
         last_lev_r  <= 3'd0;
         last_vec_r  <= 6'd0;
         cnt_r       <= '0;
         ssyn_seen_r <= 1'b0;
         br_r        <= 4'd0;
         bbsy_r      <= 1'b0;
         sack_r      <= 1'b0;
         intr_r      <= 1'b0;
         d_r         <= 16'd0;
         intdone_r   <= 1'b0;
         inttimo_r   <= 1'b0;
      end else begin
         intdone_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (new_req_s) begin
                  lev_r     <= irqlev;
                  vec_r     <= irqvec;
                  inttimo_r <= 1'b0;
                  br_r      <= lev_mask(irqlev);
                  cnt_r     <= '0;
                  state_r   <= ST_REQ;
               end else if (irqlev[2] == 1'b0) begin
                  // Level 0 never matches a request, so this re-arms any value.
                  last_lev_r <= 3'd0;
                  last_vec_r <= 6'd0;
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_REQ: begin
               // Debounce completion outranks a request change on the same edge.
               if (grant_s && (cnt_r == DEBNC_LAST)) begin
                  sack_r  <= 1'b1;
                  br_r    <= 4'd0;
                  cnt_r   <= '0;
                  state_r <= ST_WAITBUS;
               end else if (req_change_s) begin
                  br_r    <= 4'd0;
                  cnt_r   <= '0;
                  state_r <= ST_IDLE;
               end else if (grant_s) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end else begin
                  cnt_r <= '0;
               end
            end
            ST_WAITBUS: begin
               if (!bbsy_in_h && !syn_msyn_in_h && !syn_ssyn_in_h) begin
                  bbsy_r  <= 1'b1;
                  sack_r  <= 1'b0;
                  d_r     <= {8'h00, vec_r, 2'b00};
                  cnt_r   <= '0;
                  state_r <= ST_INTR;
               end else begin
                  sack_r <= 1'b1;
               end
            end
            ST_INTR: begin
               if (cnt_r == SETTLE_LAST) begin
                  intr_r      <= 1'b1;
                  cnt_r       <= '0;
                  ssyn_seen_r <= 1'b0;
                  state_r     <= ST_WAITSSYN;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_WAITSSYN: begin
               if (ssyn_seen_r) begin
                  // Hold the vector SETTLE cycles past SSYN before letting go.
                  if (cnt_r == SETTLE_LAST) begin
                     intr_r      <= 1'b0;
                     bbsy_r      <= 1'b0;
                     d_r         <= 16'd0;
                     intdone_r   <= 1'b1;
                     last_lev_r  <= lev_r;
                     last_vec_r  <= vec_r;
                     cnt_r       <= '0;
                     ssyn_seen_r <= 1'b0;
                     state_r     <= ST_RELEASE;
                  end else begin
                     cnt_r <= cnt_r + CNT_W'(1);
                  end
               end else if (del_ssyn_in_h) begin
                  ssyn_seen_r <= 1'b1;
                  cnt_r       <= '0;
               end else if (cnt_r == TIMEOUT_LAST) begin
                  intr_r     <= 1'b0;
                  bbsy_r     <= 1'b0;
                  d_r        <= 16'd0;
                  inttimo_r  <= 1'b1;
                  last_lev_r <= lev_r;
                  last_vec_r <= vec_r;
                  cnt_r      <= '0;
                  state_r    <= ST_IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_RELEASE: begin
               if (!del_ssyn_in_h) begin
                  state_r <= ST_IDLE;
               end else begin
                  cnt_r <= '0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               br_r    <= 4'd0;
               bbsy_r  <= 1'b0;
               sack_r  <= 1'b0;
               intr_r  <= 1'b0;
               d_r     <= 16'd0;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign bg_out_l   = bg_out_s;
   assign br_out_h   = br_r;
   assign bbsy_out_h = bbsy_r;
   assign sack_out_h = sack_r;
   assign intr_out_h = intr_r;
   assign d_out_h    = d_r;
   assign intdone    = intdone_r;
   assign inttimo    = inttimo_r;

endmodule

// File: tb/tb_unibus_intr.sv
// tb_unibus_intr
//   Directed bench for unibus_intr: full interrupt transfer, one-shot
//   behaviour, BG debounce, grant pass-through, SSYN timeout, INIT abort.
module tb_unibus_intr;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        init_in_h = 1'b0;
   logic [2:0]  irqlev = 3'd0;
   logic [5:0]  irqvec = 6'd0;
   logic [3:0]  bg_in_l = 4'hF;
   logic [3:0]  bg_out_l;
   logic [3:0]  br_out_h;
   logic        bbsy_in_h = 1'b0;
   logic        syn_msyn_in_h = 1'b0;
   logic        syn_ssyn_in_h = 1'b0;
   logic        del_ssyn_in_h = 1'b0;
   logic        bbsy_out_h;
   logic        sack_out_h;
   logic        intr_out_h;
   logic [15:0] d_out_h;
   logic        intdone;
   logic        inttimo;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   unibus_intr dut (
      .CLOCK(CLOCK), .RESET(RESET), .init_in_h(init_in_h),
      .irqlev(irqlev), .irqvec(irqvec),
      .bg_in_l(bg_in_l), .bg_out_l(bg_out_l), .br_out_h(br_out_h),
      .bbsy_in_h(bbsy_in_h), .syn_msyn_in_h(syn_msyn_in_h),
      .syn_ssyn_in_h(syn_ssyn_in_h), .del_ssyn_in_h(del_ssyn_in_h),
      .bbsy_out_h(bbsy_out_h), .sack_out_h(sack_out_h), .intr_out_h(intr_out_h),
      .d_out_h(d_out_h), .intdone(intdone), .inttimo(inttimo)
   );

   always #5 CLOCK = ~CLOCK;

   // Count intdone pulses, sampled away from the active edge.
   always @(negedge CLOCK) begin
      if (intdone) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge CLOCK);
         #1;
      end
   endtask

   // Hold BG low for exactly the debounce time and expect SACK.
   task automatic grant(input logic [3:0] bg);
      bg_in_l = bg;
      tick(3);
      chk("sack_early", {15'd0, sack_out_h}, 16'd0);
      tick(1);
      chk("sack", {15'd0, sack_out_h}, 16'd1);
      chk("br_drop", {12'd0, br_out_h}, 16'd0);
   endtask

   // From SACK onward: vector on D, INTR, SSYN handshake, one intdone.
   task automatic finish_xfer(input logic [15:0] exp_d);
      int start_done;
      int k;
      start_done = done_cnt;
      bg_in_l = 4'hF;
      tick(1);
      chk("d_vec", d_out_h, exp_d);
      chk("bbsy_on", {15'd0, bbsy_out_h}, 16'd1);
      chk("sack_off", {15'd0, sack_out_h}, 16'd0);
      k = 0;
      while (!intr_out_h && k < 20) begin tick(1); k++; end
      chk("intr_on", {15'd0, intr_out_h}, 16'd1);
      del_ssyn_in_h = 1'b1;
      syn_ssyn_in_h = 1'b1;
      k = 0;
      while (!intdone && k < 30) begin tick(1); k++; end
      chk("intdone", {15'd0, intdone}, 16'd1);
      chk("rel_bbsy", {15'd0, bbsy_out_h}, 16'd0);
      chk("rel_d", d_out_h, 16'd0);
      tick(1);
      del_ssyn_in_h = 1'b0;
      syn_ssyn_in_h = 1'b0;
      tick(2);
      chk("one_done", 16'(done_cnt - start_done), 16'd1);
   endtask

   initial begin
      int br_seen;
      int start_done;

      // Reset state.
      tick(2);
      RESET = 1'b0;
      tick(1);
      chk("rst_br", {12'd0, br_out_h}, 16'd0);
      chk("rst_bus", {12'd0, bbsy_out_h, sack_out_h, intr_out_h, intdone}, 16'd0);
      chk("rst_d", d_out_h, 16'd0);
      chk("rst_timo", {15'd0, inttimo}, 16'd0);
      chk("rst_bgout", {12'd0, bg_out_l}, 16'h000F);

      // First interrupt, level 5 vector 0o15, exact timing.
      irqlev = 3'd5;
      irqvec = 6'o15;
      tick(1);
      chk("br5", {12'd0, br_out_h}, 16'h0002);
      tick(20);
      chk("br5_hold", {12'd0, br_out_h}, 16'h0002);
      bg_in_l = 4'b1101;
      #1;
      chk("bg5_block", {12'd0, bg_out_l}, 16'h000F);
      tick(3);
      chk("sack_3", {15'd0, sack_out_h}, 16'd0);
      tick(1);
      chk("sack_4", {15'd0, sack_out_h}, 16'd1);
      chk("br_off", {12'd0, br_out_h}, 16'd0);
      bg_in_l = 4'hF;
      tick(1);
      chk("d_064", d_out_h, 16'o000064);
      chk("bbsy1", {15'd0, bbsy_out_h}, 16'd1);
      chk("bgout_own", {15'd0, bg_out_l[1]}, 16'd1);
      tick(14);
      chk("intr_14", {15'd0, intr_out_h}, 16'd0);
      tick(1);
      chk("intr_15", {15'd0, intr_out_h}, 16'd1);
      del_ssyn_in_h = 1'b1;
      syn_ssyn_in_h = 1'b1;
      tick(15);
      chk("done_early", {15'd0, intdone}, 16'd0);
      chk("intr_hold", {15'd0, intr_out_h}, 16'd1);
      tick(1);
      chk("done_pulse", {15'd0, intdone}, 16'd1);
      chk("intr_drop", {15'd0, intr_out_h}, 16'd0);
      tick(1);
      chk("done_1cyc", {15'd0, intdone}, 16'd0);
      del_ssyn_in_h = 1'b0;
      syn_ssyn_in_h = 1'b0;
      tick(2);
      chk("done_cnt1", 16'(done_cnt), 16'd1);

      // Same value held: no second request.
      br_seen = 0;
      for (int i = 0; i < 2000; i++) begin
         tick(1);
         if (br_out_h != 4'd0) br_seen++;
      end
      chk("no_rereq", 16'(br_seen), 16'd0);

      // Idle level re-arms the same value.
      irqlev = 3'd0;
      tick(1);
      irqlev = 3'd5;
      tick(1);
      chk("rearm_br5", {12'd0, br_out_h}, 16'h0002);
      grant(4'b1101);
      finish_xfer(16'o000064);

      // Debounce: a 2-cycle glitch does not count.
      irqlev = 3'd0;
      tick(1);
      irqlev = 3'd5;
      irqvec = 6'o21;
      tick(1);
      bg_in_l = 4'b1101;
      tick(2);
      bg_in_l = 4'hF;
      tick(1);
      chk("glitch_nosack", {15'd0, sack_out_h}, 16'd0);
      chk("glitch_bgout", {15'd0, bg_out_l[1]}, 16'd1);
      bg_in_l = 4'b1101;
      #1;
      chk("deb_bgout", {15'd0, bg_out_l[1]}, 16'd1);
      tick(3);
      chk("deb_sack3", {15'd0, sack_out_h}, 16'd0);
      tick(1);
      chk("deb_sack4", {15'd0, sack_out_h}, 16'd1);
      chk("deb_bgout2", {15'd0, bg_out_l[1]}, 16'd1);
      finish_xfer(16'o000104);

      // Change on the same edge as debounce completion: SACK wins, old vector used.
      irqlev = 3'd4;
      irqvec = 6'o01;
      tick(1);
      chk("br4", {12'd0, br_out_h}, 16'h0001);
      bg_in_l = 4'b1110;
      tick(3);
      irqvec = 6'o02;
      tick(1);
      chk("race_sack", {15'd0, sack_out_h}, 16'd1);
      finish_xfer(16'o000004);
      irqlev = 3'd0;
      tick(3);

      // Requesting BR6: BG4 passes through, no SACK.
      irqlev = 3'd6;
      irqvec = 6'o07;
      tick(1);
      chk("br6", {12'd0, br_out_h}, 16'h0004);
      bg_in_l = 4'b1110;
      #1;
      chk("bg4_pass", {12'd0, bg_out_l}, 16'h000E);
      tick(6);
      chk("bg4_nosack", {15'd0, sack_out_h}, 16'd0);

      // Grant BG6, never answer SSYN: timeout.
      start_done = done_cnt;
      grant(4'b1011);
      bg_in_l = 4'hF;
      tick(1);
      chk("d_034", d_out_h, 16'o000034);
      tick(15);
      chk("to_intr", {15'd0, intr_out_h}, 16'd1);
      tick(999);
      chk("to_hold", {15'd0, bbsy_out_h}, 16'd1);
      tick(1);
      chk("to_drop", {12'd0, bbsy_out_h, intr_out_h, sack_out_h, intdone}, 16'd0);
      chk("to_d", d_out_h, 16'd0);
      chk("to_br", {12'd0, br_out_h}, 16'd0);
      chk("to_timo", {15'd0, inttimo}, 16'd1);
      tick(5);
      chk("to_sticky", {15'd0, inttimo}, 16'd1);
      chk("to_nodone", 16'(done_cnt - start_done), 16'd0);

      // New request clears inttimo; INIT during WAITSSYN drops everything.
      irqlev = 3'd0;
      tick(1);
      irqlev = 3'd7;
      irqvec = 6'o33;
      tick(1);
      chk("br7", {12'd0, br_out_h}, 16'h0008);
      chk("timo_clr", {15'd0, inttimo}, 16'd0);
      grant(4'b0111);
      bg_in_l = 4'hF;
      tick(16);
      chk("init_pre_intr", {15'd0, intr_out_h}, 16'd1);
      init_in_h = 1'b1;
      tick(1);
      init_in_h = 1'b0;
      chk("init_bus", {12'd0, bbsy_out_h, intr_out_h, sack_out_h, intdone}, 16'd0);
      chk("init_d", d_out_h, 16'd0);
      chk("init_br", {12'd0, br_out_h}, 16'd0);
      chk("init_bgout", {12'd0, bg_out_l}, 16'h000F);

      // Request change before grant aborts, then the new value requests.
      irqlev = 3'd0;
      tick(2);
      irqlev = 3'd4;
      irqvec = 6'o10;
      tick(1);
      chk("ab_br4", {12'd0, br_out_h}, 16'h0001);
      irqlev = 3'd6;
      tick(1);
      chk("ab_drop", {12'd0, br_out_h}, 16'd0);
      tick(1);
      chk("ab_br6", {12'd0, br_out_h}, 16'h0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
